// File: rtl/dp_ram_pkg.sv
// rtl/dp_ram_pkg.sv - shared types, constants and byte-lane merge helper for dp_ram_clr
package dp_ram_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // Widest word the merge helper handles; callers zero-extend and truncate.
  localparam int MERGE_MAX_W  = 256;
  localparam int MERGE_MAX_BE = MERGE_MAX_W / 8;

  function automatic logic [MERGE_MAX_W-1:0] merge_bytes(
    input logic [MERGE_MAX_W-1:0]  old_w,
    input logic [MERGE_MAX_W-1:0]  new_w,
    input logic [MERGE_MAX_BE-1:0] be
  );
    logic [MERGE_MAX_W-1:0] r;
    r = old_w;
    for (int i = 0; i < MERGE_MAX_BE; i++) begin
      if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dp_ram_clr_fsm.sv
// rtl/dp_ram_clr_fsm.sv - clear sweep controller: walks every address writing zero, then runs
module dp_ram_clr_fsm
  import dp_ram_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              busy,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              clr_we
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      CLEAR: begin
        cnt_nxt = cnt + ADDR_W'(1);
        if (cnt == '1) state_nxt = RUN;
      end
      RUN: begin
        if (clr) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  // busy is the state register itself, so it is glitch-free and registered.
  assign busy     = (state == CLEAR);
  assign clr_we   = (state == CLEAR) && !rst;
  assign clr_addr = cnt;

endmodule

// File: rtl/dp_ram_clr.sv
// rtl/dp_ram_clr.sv - true dual-port RAM with byte enables, collision arbitration and sweep clear
module dp_ram_clr
  import dp_ram_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int RDW_MODE = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en_a,
  input  logic                we_a,
  input  logic [DATA_W/8-1:0] be_a,
  input  logic [ADDR_W-1:0]   addr_a,
  input  logic [DATA_W-1:0]   wdata_a,
  output logic [DATA_W-1:0]   rdata_a,
  output logic                rvalid_a,
  input  logic                en_b,
  input  logic                we_b,
  input  logic [DATA_W/8-1:0] be_b,
  input  logic [ADDR_W-1:0]   addr_b,
  input  logic [DATA_W-1:0]   wdata_b,
  output logic [DATA_W-1:0]   rdata_b,
  output logic                rvalid_b,
  output logic                busy,
  output logic                collision
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int BE_W  = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] clr_addr;
  logic              clr_we;

  dp_ram_clr_fsm #(.ADDR_W(ADDR_W)) u_fsm (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .busy     (busy),
    .clr_addr (clr_addr),
    .clr_we   (clr_we)
  );

  function automatic logic [DATA_W-1:0] merge(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [BE_W-1:0]   be
  );
    return DATA_W'(merge_bytes(MERGE_MAX_W'(old_w), MERGE_MAX_W'(new_w), MERGE_MAX_BE'(be)));
  endfunction

  logic              acc_a, acc_b, wr_a, wr_b, same_addr;
  logic [DATA_W-1:0] old_a, old_b, new_a, new_b, both_word;

  always_comb begin
    acc_a     = en_a && !busy && !rst;
    acc_b     = en_b && !busy && !rst;
    wr_a      = acc_a && we_a;
    wr_b      = acc_b && we_b;
    same_addr = (addr_a == addr_b);
    old_a     = mem[addr_a];
    old_b     = mem[addr_b];
    new_a     = merge(old_a, wdata_a, be_a);
    new_b     = merge(old_b, wdata_b, be_b);
    // A is layered over B so A owns every lane both ports enable.
    both_word = merge(new_b, wdata_a, be_a);
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_a && wr_b && same_addr) begin
      mem[addr_a] <= both_word;
    end else begin
      if (wr_a) mem[addr_a] <= new_a;
      if (wr_b) mem[addr_b] <= new_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_a   <= '0;
      rdata_b   <= '0;
      rvalid_a  <= 1'b0;
      rvalid_b  <= 1'b0;
      collision <= 1'b0;
    end else begin
      rvalid_a  <= acc_a;
      rvalid_b  <= acc_b;
      if (acc_a) rdata_a <= (RDW_MODE == RDW_WRITE_FIRST && wr_a) ? new_a : old_a;
      if (acc_b) rdata_b <= (RDW_MODE == RDW_WRITE_FIRST && wr_b) ? new_b : old_b;
      collision <= wr_a && wr_b && same_addr && (|(be_a & be_b));
    end
  end

endmodule

// File: tb/tb_dp_ram_clr.sv
// tb/tb_dp_ram_clr.sv - self-checking bench for dp_ram_clr in read-first and write-first modes
module tb_dp_ram_clr;

  logic        clk, rst, clr;
  logic        en_a, we_a, en_b, we_b;
  logic [1:0]  be_a, be_b;
  logic [3:0]  addr_a, addr_b;
  logic [15:0] wdata_a, wdata_b;
  logic [15:0] ra0, rb0, ra1, rb1;
  logic        va0, vb0, va1, vb1, busy0, busy1, col0, col1;

  int n_pass  = 0;
  int n_total = 0;

  dp_ram_clr #(.DATA_W(16), .ADDR_W(4), .RDW_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .clr(clr),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .rdata_a(ra0), .rvalid_a(va0),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .rdata_b(rb0), .rvalid_b(vb0),
    .busy(busy0), .collision(col0)
  );

  dp_ram_clr #(.DATA_W(16), .ADDR_W(4), .RDW_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .clr(clr),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .rdata_a(ra1), .rvalid_a(va1),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .rdata_b(rb1), .rvalid_b(vb1),
    .busy(busy1), .collision(col1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: word array plus remaining-sweep bookkeeping.
  logic [15:0] mmem [16];
  bit          m_on = 0, m_clear = 0;
  int          m_sweep = 0;
  logic [15:0] e_ra0, e_ra1, e_rb0, e_rb1, oa, ob;
  bit          e_va, e_vb, e_col;

  function automatic logic [15:0] lanes(input logic [15:0] o, input logic [15:0] n,
                                        input logic [1:0] be);
    logic [15:0] r;
    r = o;
    if (be[0]) r[7:0]  = n[7:0];
    if (be[1]) r[15:8] = n[15:8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_on = 1; m_clear = 1; m_sweep = 0;
      e_ra0 = 0; e_ra1 = 0; e_rb0 = 0; e_rb1 = 0;
      e_va = 0; e_vb = 0; e_col = 0;
    end else if (m_on) begin
      e_va = 0; e_vb = 0; e_col = 0;
      if (m_clear) begin
        mmem[m_sweep] = 16'h0;
        m_sweep++;
        if (m_sweep == 16) m_clear = 0;
      end else begin
        oa = mmem[addr_a];
        ob = mmem[addr_b];
        if (en_a) begin
          e_va = 1; e_ra0 = oa;
          e_ra1 = we_a ? lanes(oa, wdata_a, be_a) : oa;
        end
        if (en_b) begin
          e_vb = 1; e_rb0 = ob;
          e_rb1 = we_b ? lanes(ob, wdata_b, be_b) : ob;
        end
        if (en_b && we_b) mmem[addr_b] = lanes(mmem[addr_b], wdata_b, be_b);
        if (en_a && we_a) mmem[addr_a] = lanes(mmem[addr_a], wdata_a, be_a);
        e_col = en_a && we_a && en_b && we_b && (addr_a == addr_b) && ((be_a & be_b) != 0);
        if (clr) begin m_clear = 1; m_sweep = 0; end
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("m0_rdata_a", ra0, e_ra0);  chk("m1_rdata_a", ra1, e_ra1);
      chk("m0_rdata_b", rb0, e_rb0);  chk("m1_rdata_b", rb1, e_rb1);
      chk("m0_rvalid_a", 16'(va0), 16'(e_va)); chk("m1_rvalid_a", 16'(va1), 16'(e_va));
      chk("m0_rvalid_b", 16'(vb0), 16'(e_vb)); chk("m1_rvalid_b", 16'(vb1), 16'(e_vb));
      chk("m0_collision", 16'(col0), 16'(e_col)); chk("m1_collision", 16'(col1), 16'(e_col));
      chk("m0_busy", 16'(busy0), 16'(m_clear)); chk("m1_busy", 16'(busy1), 16'(m_clear));
    end
  end

  task automatic set_a(input logic en, input logic we, input logic [1:0] be,
                       input logic [3:0] addr, input logic [15:0] data);
    en_a = en; we_a = we; be_a = be; addr_a = addr; wdata_a = data;
  endtask

  task automatic set_b(input logic en, input logic we, input logic [1:0] be,
                       input logic [3:0] addr, input logic [15:0] data);
    en_b = en; we_b = we; be_b = be; addr_b = addr; wdata_b = data;
  endtask

  task automatic idle();
    set_a(1'b0, 1'b0, 2'b00, 4'd0, 16'h0);
    set_b(1'b0, 1'b0, 2'b00, 4'd0, 16'h0);
  endtask

  // Counts negedges with busy high starting at the current one.
  task automatic busy_len(output int n);
    n = 0;
    while (busy0 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n;

  initial begin
    rst = 1'b1; clr = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    chk("rst_busy", 16'(busy0), 16'h1);
    chk("rst_rdata_a", ra0, 16'h0);
    chk("rst_rvalid_a", 16'(va0), 16'h0);
    rst = 1'b0;
    busy_len(n);
    chk("init_busy_len", 16'(n), 16'd16);

    for (int i = 0; i < 16; i++) begin
      set_a(1'b1, 1'b0, 2'b00, 4'(i), 16'h0);
      @(negedge clk);
      chk("clear_read", ra0, 16'h0000);
      chk("clear_rvalid", 16'(va0), 16'h1);
    end
    idle();

    set_a(1'b1, 1'b1, 2'b11, 4'd3, 16'hBEEF);
    @(negedge clk);
    set_a(1'b0, 1'b0, 2'b00, 4'd0, 16'h0);
    set_b(1'b1, 1'b1, 2'b10, 4'd3, 16'h1200);
    @(negedge clk);
    idle();
    set_a(1'b1, 1'b0, 2'b00, 4'd3, 16'h0);
    @(negedge clk);
    chk("be_merge", ra0, 16'h12EF);

    set_a(1'b1, 1'b1, 2'b11, 4'd5, 16'h0011);
    @(negedge clk);
    set_a(1'b1, 1'b1, 2'b11, 4'd5, 16'h2233);
    set_b(1'b1, 1'b0, 2'b00, 4'd5, 16'h0);
    @(negedge clk);
    chk("rdw_read_first", ra0, 16'h0011);
    chk("rdw_write_first", ra1, 16'h2233);
    chk("rdw_cross_m0", rb0, 16'h0011);
    chk("rdw_cross_m1", rb1, 16'h0011);
    idle();

    set_a(1'b1, 1'b1, 2'b11, 4'd7, 16'hAAAA);
    set_b(1'b1, 1'b1, 2'b11, 4'd7, 16'h5555);
    @(negedge clk);
    chk("collision_pulse", 16'(col0), 16'h1);
    idle();
    set_a(1'b1, 1'b0, 2'b00, 4'd7, 16'h0);
    @(negedge clk);
    chk("collision_clear", 16'(col0), 16'h0);
    chk("collision_winner", ra0, 16'hAAAA);

    set_a(1'b1, 1'b1, 2'b01, 4'd8, 16'hAAAA);
    set_b(1'b1, 1'b1, 2'b10, 4'd8, 16'h5555);
    @(negedge clk);
    chk("disjoint_no_collision", 16'(col0), 16'h0);
    idle();
    set_a(1'b1, 1'b0, 2'b00, 4'd8, 16'h0);
    @(negedge clk);
    chk("disjoint_readback", ra0, 16'h55AA);

    set_a(1'b1, 1'b0, 2'b00, 4'd3, 16'h0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_edge_read", ra0, 16'h12EF);
    chk("clr_edge_rvalid", 16'(va0), 16'h1);
    chk("clr_busy_rise", 16'(busy0), 16'h1);
    n = 1;
    @(negedge clk);
    while (busy0 && n < 40) begin
      chk("clr_read_ignored", 16'(va0), 16'h0);
      n++;
      @(negedge clk);
    end
    chk("clr_busy_len", 16'(n), 16'd16);
    @(negedge clk);
    chk("post_clr_read", ra0, 16'h0000);
    idle();

    set_a(1'b1, 1'b1, 2'b11, 4'd2, 16'h1234);
    @(negedge clk);
    idle();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    set_a(1'b1, 1'b0, 2'b00, 4'd2, 16'h0);
    @(negedge clk);
    chk("midsweep_rst_busy", 16'(busy0), 16'h1);
    chk("midsweep_rst_rvalid", 16'(va0), 16'h0);
    rst = 1'b0;
    busy_len(n);
    chk("midsweep_busy_len", 16'(n), 16'd16);
    idle();

    for (int i = 0; i < 200; i++) begin
      set_a(1'((i % 3) != 0), 1'((i % 2) == 1), 2'(i % 4), 4'(i * 5), 16'(i * 16'h1357));
      set_b(1'((i % 4) != 1), 1'((i % 3) == 1), 2'((i >> 1) % 4), 4'(i * 7), 16'(i * 16'h2461 + 7));
      clr = (i == 120);
      @(negedge clk);
    end
    clr = 1'b0;
    idle();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
